fm_modulator: RTL and testbench
===============================

# fm_modulator

Transmit-side FM modulator, the counterpart to the radio core's receive chain. It accepts signed base-band samples over a valid/ready handshake, one sample per M clock cycles. It turns each sample into a frequency offset around the carrier phase constant K and accumulates phase at the sampling clock rate. It drives a 1-bit square-wave carrier (DDS MSB) for an external 1-bit DAC/driver, plus the top two phase bits for quadrature use.

## Interface
- width_dds, 32, DDS phase accumulator width
- width_in, 17, base-band sample width (signed)
- M, 240, sampling-clock cycles per base-band sample (M ≥ 2)
- SHIFT, 0, left shift applied to the scaled offset before adding to K (deviation gain)

- clk  in  1  sampling clock
- reset  in  1  reset; synchronous, active-high
- K  in  width_dds  carrier phase constant (unsigned)
- in_data  in  width_in  signed base-band sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- tx  out  1  modulated 1-bit carrier
- phase_q  out  2  top two bits of DDS phase
- underrun  out  1  one-cycle pulse: period boundary with no buffered sample

## Operation
- Datapath elements:
  - one-entry input buffer `buf`, with a `buf_full` flag
  - current sample `cur`
  - period counter `cnt`, counts 0..M-1 and wraps
  - offset register `off`, signed, width_in+$clog2(M)+1 bits
  - phase accumulator `phase`, width_dds bits
- Handshake:
  - in_ready = !buf_full || (cnt == M-1), combinational.
  - A transfer occurs on a rising clk edge when in_valid && in_ready.
- Period boundary (edge where cnt == M-1):
  - If buf_full: cur <= buf and the buffer empties.
  - If a transfer occurs on the same edge, buf takes the new in_data and stays full.
  - If !buf_full: cur is held, underrun pulses high for the following cycle, and any same-edge transfer fills buf.
- Transfer outside a boundary: buf <= in_data, buf_full <= 1.
- Offset, zero-order hold (default): off <= cur * M, registered every cycle.
- Phase: phase <= phase + K + (off <<< SHIFT), sign-extended and truncated modulo 2^width_dds. Wrap-around is intended.
- Outputs:
  - tx <= phase[width_dds-1], registered.
  - phase_q <= phase[width_dds-1 -: 2], registered.
- K is sampled every cycle; a change takes effect on the next phase update.

## Timing
- Reset values: in_ready=1, tx=0, phase_q=0, underrun=0. Internal: cnt=0, buf_full=0, cur=0, off=0, phase=0, step=0.
- Reset mid-operation discards buf and cur. The first sample after reset is accepted on the first cycle reset is low and in_valid is high.
- Latency from boundary load of cur to tx reflecting the new frequency:
  - off updates 1 cycle after cur.
  - phase uses the new off 1 cycle after that.
  - tx follows 1 cycle later.
  - Total: 3 cycles after the boundary edge.
- Sustained rate: one sample per M cycles. A source that keeps in_valid high is throttled so that exactly one transfer happens per period after the buffer first fills.
- No other states exist. The counter runs freely from reset; it is not gated by data.

## Configuration
- FM_MOD_LINEAR_INTERP_EN defined:
  - At each boundary load, step <= buf - cur, using cur's old value. On underrun, step <= 0.
  - Every cycle: off <= off + step.
  - Over one period, off ramps linearly from old_cur*M to new_cur*M. It reaches the endpoint exactly, with no accumulated error.
  - Tx latency is unchanged. The full sample value is reached M cycles after the boundary.
- FM_MOD_LINEAR_INTERP_EN undefined:
  - Zero-order hold as above.
  - No step register is synthesised.

## Test plan
- Reset/idle: M=4, K=2^30, width_dds=32, no input → tx toggles every 2 cycles (period 4), phase_q counts 0,1,2,3; underrun pulses once per 4 cycles. Asserting reset mid-stream → tx=0, phase_q=0 and in_ready=1 on the next cycle.
- Handshake back-pressure: in_valid held high with an incrementing sample stream, M=4 → exactly one transfer per 4 cycles after the first fill. in_ready is low except at cnt==3, with no lost or duplicated samples; check against a scoreboard.
- Frequency offset: M=4, SHIFT=20, K=2^30, constant sample +64 → effective increment 2^30 + 256·2^20 = 2^30 + 2^28. The tx period is then 2^32/(1.25·2^30) = 3.2 cycles on average; the phase value is checked exactly after 100 cycles.
- Underrun: stop input after sample 5 → underrun pulses at every subsequent boundary. cur stays at sample 5, and the tx frequency is unchanged.
- Wrap-around: K=2^32-1 with negative offset −K → phase is constant, and tx is constant after latency.
- With FM_MOD_LINEAR_INTERP_EN, M=4, samples 0 then 8 → off steps 0,8,16,24,32 over the period, ending exactly at 32 = 8·4.

Source files
------------

// File: rtl/fm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : fm_modulator
//  Description : Transmit-side FM modulator. Accepts one signed base-band
//                sample per M clock cycles over valid/ready, converts it to a
//                frequency offset around carrier constant K and drives the
//                DDS MSB as a 1-bit carrier plus the top two phase bits.
//                Optional build macro FM_MOD_LINEAR_INTERP_EN replaces the
//                zero-order-hold offset with a per-period linear ramp.
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_modulator #(
  parameter int WIDTH_DDS = 32,
  parameter int WIDTH_IN  = 17,
  parameter int M         = 240,
  parameter int SHIFT     = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [WIDTH_DDS-1:0] k_i,
  input  logic [WIDTH_IN-1:0]  in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 tx_o,
  output logic [1:0]           phase_q_o,
  output logic                 underrun_o
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  // Offset must hold cur*M without overflow for any signed sample.
  localparam int OW = WIDTH_IN + $clog2(M) + 1;
  // Intermediate width for the shifted offset; never narrower than the DDS.
  localparam int EW = ((OW + SHIFT) > WIDTH_DDS) ? (OW + SHIFT) : WIDTH_DDS;
  localparam logic [CW-1:0]        CNT_LAST = CW'(M - 1);
  localparam logic signed [OW-1:0] M_S      = OW'(M);

  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [WIDTH_IN-1:0]  buf_q, buf_d;
  logic                        buf_full_q, buf_full_d;
  logic signed [WIDTH_IN-1:0]  cur_q, cur_d;
  logic signed [OW-1:0]        off_q, off_d;
  logic [WIDTH_DDS-1:0]        phase_q, phase_d;
  logic                        tx_q;
  logic [1:0]                  quad_q;
  logic                        underrun_q, underrun_d;

  logic                        w_boundary;
  logic                        w_xfer;
  logic signed [EW-1:0]        w_off_ext;
  logic signed [EW-1:0]        w_off_sh;

`ifdef FM_MOD_LINEAR_INTERP_EN
  localparam int SW = WIDTH_IN + 1;
  logic signed [SW-1:0]        step_q, step_d;
`endif

  assign w_boundary = (cnt_q == CNT_LAST);
  // The boundary slot frees the buffer, so a new sample may enter even when full.
  assign in_ready_o = !buf_full_q || w_boundary;
  assign w_xfer     = in_valid_i && in_ready_o;

  // Period counter, input buffer and current-sample handover.
  always_comb begin
    cnt_d      = w_boundary ? '0 : cnt_q + CW'(1);
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cur_d      = cur_q;
    underrun_d = 1'b0;
    if (w_boundary) begin
      if (buf_full_q) begin
        cur_d      = buf_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
    if (w_xfer) begin
      buf_d      = in_data_i;
      buf_full_d = 1'b1;
    end
  end

`ifdef FM_MOD_LINEAR_INTERP_EN
  // Linear ramp: slope is the sample difference, so M steps land exactly on new_cur*M.
  always_comb begin
    step_d = step_q;
    if (w_boundary) begin
      if (buf_full_q) begin
        step_d = SW'(buf_q) - SW'(cur_q);
      end else begin
        step_d = '0;
      end
    end
    off_d = off_q + OW'(step_q);
  end
`else
  // Zero-order hold: offset tracks the current sample scaled by M.
  always_comb begin
    off_d = OW'(cur_q) * M_S;
  end
`endif

  assign w_off_ext = EW'(off_q);
  assign w_off_sh  = w_off_ext <<< SHIFT;

  // Phase accumulation wraps modulo 2^WIDTH_DDS by design.
  always_comb begin
    phase_d = phase_q + k_i + w_off_sh[WIDTH_DDS-1:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cur_q      <= '0;
      off_q      <= '0;
      phase_q    <= '0;
      tx_q       <= 1'b0;
      quad_q     <= 2'b00;
      underrun_q <= 1'b0;
`ifdef FM_MOD_LINEAR_INTERP_EN
      step_q     <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cur_q      <= cur_d;
      off_q      <= off_d;
      phase_q    <= phase_d;
      tx_q       <= phase_q[WIDTH_DDS-1];
      quad_q     <= phase_q[WIDTH_DDS-1 -: 2];
      underrun_q <= underrun_d;
`ifdef FM_MOD_LINEAR_INTERP_EN
      step_q     <= step_d;
`endif
    end
  end

  assign tx_o       = tx_q;
  assign phase_q_o  = quad_q;
  assign underrun_o = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fm_modulator
//  Description : Directed self-checking bench for fm_modulator (M=4,
//                SHIFT=20, 32-bit DDS) with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_modulator;

  localparam int M     = 4;
  localparam int SHIFT = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] k = '0;
  logic [16:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        tx;
  logic [1:0]  pq;
  logic        underrun;

  int n_vec  = 0;
  int n_fail = 0;

  fm_modulator #(
    .WIDTH_DDS(32),
    .WIDTH_IN (17),
    .M        (M),
    .SHIFT    (SHIFT)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .k_i       (k),
    .in_data_i (in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .tx_o      (tx),
    .phase_q_o (pq),
    .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint      m_bq[$];
  longint      m_cur, m_off, m_step;
  int          m_cnt;
  logic [31:0] m_phase;
  logic        m_tx, m_under;
  logic [1:0]  m_pq;
  bit          m_started = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    logic [31:0] nphase;
    longint      noff;
    bit          rdy, xfer, nunder;
    if (reset) begin
      m_bq.delete();
      m_cur = 0; m_off = 0; m_step = 0; m_cnt = 0;
      m_phase = '0; m_tx = 1'b0; m_pq = 2'b00; m_under = 1'b0;
      cyc = 0;
      m_started = 1;
    end else begin
      rdy    = (m_bq.size() == 0) || (m_cnt == M - 1);
      xfer   = in_valid && rdy;
      nphase = m_phase + k + 32'(m_off * (longint'(1) << SHIFT));
`ifdef FM_MOD_LINEAR_INTERP_EN
      noff = m_off + m_step;
`else
      noff = m_cur * M;
`endif
      nunder = 0;
      if (m_cnt == M - 1) begin
        if (m_bq.size() != 0) begin
`ifdef FM_MOD_LINEAR_INTERP_EN
          m_step = m_bq[0] - m_cur;
`endif
          m_cur = m_bq.pop_front();
        end else begin
          nunder = 1;
`ifdef FM_MOD_LINEAR_INTERP_EN
          m_step = 0;
`endif
        end
      end
      if (xfer) m_bq.push_back(longint'($signed(in_data)));
      m_cnt   = (m_cnt + 1) % M;
      m_tx    = m_phase[31];
      m_pq    = m_phase[31:30];
      m_phase = nphase;
      m_off   = noff;
      m_under = nunder;
      cyc++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("tx", 32'(tx), 32'(m_tx));
      chk("phase_q", 32'(pq), 32'(m_pq));
      chk("underrun", 32'(underrun), 32'(m_under));
      chk("in_ready", 32'(in_ready), 32'((m_bq.size() == 0) || (m_cnt == M - 1)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < target + 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cyc_timeout", 32'(cyc >= target), 32'd1);
  endtask

  // Presents one sample and returns on the edge where it was accepted.
  task automatic send(input logic [16:0] v, output int tcyc);
    bit r = 0;
    int n = 0;
    tcyc = -1;
    #2;
    in_valid = 1'b1;
    in_data  = v;
    while (!r && n < 10 * M) begin
      @(negedge clk);
      r    = in_ready;
      tcyc = cyc + 1;
      @(posedge clk);
      n++;
    end
    chk("send_timeout", 32'(r), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int tc[12];
    int cnt_u, changes;
    logic prev;

    // Reset state
    k = 32'h4000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd0);
    chk("rst_phase_q", 32'(pq), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);

    // Idle carrier, K = 2^30, no input
    do_reset();
    wait_cyc(3);
    chk("idle_pq3", 32'(pq), 32'd2);
    chk("idle_tx3", 32'(tx), 32'd1);
    chk("idle_un3", 32'(underrun), 32'd0);
    wait_cyc(4);
    chk("idle_pq4", 32'(pq), 32'd3);
    chk("idle_un4", 32'(underrun), 32'd1);
    wait_cyc(5);
    chk("idle_pq5", 32'(pq), 32'd0);
    chk("idle_tx5", 32'(tx), 32'd0);
    wait_cyc(8);
    chk("idle_un8", 32'(underrun), 32'd1);

    // Back-pressure: incrementing stream with valid held high
    do_reset();
    for (int i = 0; i < 12; i++) send(17'(i + 1), tc[i]);
    chk("bp_first_xfer", 32'(tc[0]), 32'd1);
    chk("bp_second_xfer", 32'(tc[1]), 32'd4);
    chk("bp_last_xfer", 32'(tc[11]), 32'd44);
    // Mid-stream reset with a sample still buffered
    #2 in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mrst_tx", 32'(tx), 32'd0);
    chk("mrst_phase_q", 32'(pq), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);

    // Frequency offset: constant +64 sample, SHIFT=20
    do_reset();
    k = 32'h4000_0000;
    in_data = 17'd64;
    in_valid = 1'b1;
`ifndef FM_MOD_LINEAR_INTERP_EN
    wait_cyc(100);
    chk("freq_pq100", 32'(pq), 32'd2);
    wait_cyc(101);
    chk("freq_pq101", 32'(pq), 32'd3);
    chk("freq_tx101", 32'(tx), 32'd1);
`else
    wait_cyc(101);
`endif

    // Underrun: five samples then silence
    do_reset();
    for (int i = 0; i < 5; i++) send(17'(i + 1), tc[i]);
    #2 in_valid = 1'b0;
    wait_cyc(20);
    cnt_u = 0;
    repeat (20) begin
      @(negedge clk);
      if (underrun) cnt_u++;
    end
    chk("under_pulses", 32'(cnt_u), 32'd5);

    // Wrap-around: K + offset == 0 mod 2^32 once the sample is applied
    do_reset();
    k = 32'hFFC0_0000;
    in_data = 17'd1;
    in_valid = 1'b1;
`ifndef FM_MOD_LINEAR_INTERP_EN
    wait_cyc(10);
    prev = tx;
    changes = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== prev) changes++;
      prev = tx;
    end
    chk("wrap_pq", 32'(pq), 32'd3);
    chk("wrap_tx", 32'(tx), 32'd1);
    chk("wrap_tx_changes", 32'(changes), 32'd0);
`else
    wait_cyc(40);
`endif
    #2 in_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
